adder_serial_nbit: RTL and testbench
====================================

ADDER_SERIAL_NBIT -- requirements
Module: adder_serial_nbit

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits; SHALL be >= 1.
REQ-002 Parameter CHUNK, default 4, bits added per clock; SHALL be >= 1, <= WIDTH, and divide WIDTH exactly.
REQ-003 Local NCHUNK = WIDTH/CHUNK SHALL be the number of add cycles per operation.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin an addition; sampled at clk rising edge.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, same encoding as A.
REQ-009 carry_in  input  1  carry into bit 0.
REQ-010 busy  output  1  high while an operation is in progress; start is not accepted.
REQ-011 done  output  1  single-cycle pulse; result outputs are valid.
REQ-012 sum  output  WIDTH  registered result A+B+carry_in, modulo 2^WIDTH.
REQ-013 carry_out  output  1  carry out of bit WIDTH-1.
REQ-014 overflow  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR carry_out.

Function
REQ-015 FSM states IDLE, CALC, DONE.
- IDLE: busy=0, done=0.
- CALC: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-016 IDLE, start=1 -> capture a, b, carry_in into internal registers; clear chunk index to 0; go to CALC.
REQ-017 IDLE, start=0 -> stay in IDLE; no register changes.
REQ-018 CALC, each edge -> add chunk [i*CHUNK +: CHUNK] of the captured operands plus the running carry; write it into the internal accumulator; store the new running carry; increment i.
REQ-019 CALC, edge processing chunk NCHUNK-1 -> load sum, carry_out and overflow from the completed accumulator and carries in that same edge; go to DONE.
REQ-020 Latency: start accepted at edge E0; done is high for exactly the cycle following edge E0+NCHUNK.
REQ-021 DONE, start=1 -> accept a new operation exactly as from IDLE (back-to-back); done SHALL still last only one cycle.
REQ-022 DONE, start=0 -> go to IDLE.
REQ-023 start=1 while in CALC -> ignored; captured operands and progress unaffected; no queuing.
REQ-024 Changes on a, b or carry_in after capture SHALL NOT affect the operation in progress.
REQ-025 sum, carry_out and overflow SHALL hold their last values until the next completion.
- They SHALL NOT show partial results during CALC.
REQ-026 CHUNK=WIDTH (NCHUNK=1) -> one CALC cycle; done in the cycle after edge E0+1.
REQ-027 The chunk index SHALL be wide enough for NCHUNK-1 and SHALL NOT wrap during an operation.
REQ-028 Simulation-only check: $error when start, or carry_in at capture, is not 0 or 1 (X/Z).

Reset
REQ-029 rst=1 at a rising edge -> state IDLE; chunk index 0; running carry 0.
- Outputs: busy=0, done=0, sum=0, carry_out=0, overflow=0.
REQ-030 rst has priority over start in the same cycle; an operation in progress is abandoned with no done pulse.
REQ-031 First start is accepted at the first edge where rst=0.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 a=0xFFFF, b=0x0001, carry_in=0, start pulse at E0 -> busy high 4 cycles, done pulse after E0+4; sum=0x0000, carry_out=1, overflow=0.
REQ-033 a=0x7FFF, b=0x0001, carry_in=0 -> sum=0x8000, carry_out=0, overflow=1.
REQ-034 a=0x1234, b=0x4321, carry_in=1, start held high 10 cycles -> results 0x5556 / 0 / 0 with done on each completion; starts during CALC ignored; back-to-back acceptance from DONE.
REQ-035 rst asserted 2 cycles after start -> outputs all 0 next cycle; no done pulse; a new start afterwards completes normally.
REQ-036 Change a, b mid-operation from 0x0003+0x0004 -> sum=0x0007, unaffected.
REQ-037 WIDTH=8, CHUNK=8: a=0x80, b=0x80 -> done after E0+1; sum=0x00, carry_out=1, overflow=1.

Source files
------------

// File: rtl/adder_serial_nbit.sv
// ============================================================================
// Module      : adder_serial_nbit
// Description : Multi-cycle adder that sums two WIDTH-bit operands CHUNK bits
//               per clock, LSB chunk first, and reports sum, carry-out and
//               two's-complement overflow with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_serial_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  // Captured operands are shifted right each CALC cycle, so the chunk being
  // added is always in the low CHUNK bits; the original MSBs end up in the
  // top of the low chunk on the final cycle.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Accumulator fills from the top: each new chunk enters at the MSB end and
  // earlier chunks move down, so after NCHUNK cycles it holds the full sum.
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic [CHUNK:0]   chunk_sum_d;
  logic [WIDTH-1:0] acc_d;
  logic             msb_cin_d;
  logic             overflow_d;

  // Chunk adder, accumulator merge and overflow from the carry into the MSB.
  always_comb begin
    chunk_sum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
    acc_d       = WIDTH'({chunk_sum_d[CHUNK-1:0], acc_q} >> CHUNK);
    // Only meaningful on the last chunk, where bit CHUNK-1 is operand bit WIDTH-1.
    msb_cin_d   = chunk_sum_d[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    overflow_d  = msb_cin_d ^ chunk_sum_d[CHUNK];
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc_q   <= acc_d;
          carry_q <= chunk_sum_d[CHUNK];
          if (idx_q == LAST_IDX) begin
            sum_q       <= acc_d;
            carry_out_q <= chunk_sum_d[CHUNK];
            overflow_q  <= overflow_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Flag unknown control values reaching the FSM while out of reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(start)) else $error("adder_serial_nbit: start is X/Z");
      if (start === 1'b1 && state_q != ST_CALC) begin
        assert (!$isunknown(carry_in)) else $error("adder_serial_nbit: carry_in is X/Z at capture");
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_serial_nbit.sv
// ============================================================================
// Module      : tb_adder_serial_nbit
// Description : Self-checking bench for adder_serial_nbit (16/4 and 8/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_serial_nbit;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        carry_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, carry_out, overflow;
  logic [15:0] sum;

  logic        start8 = 1'b0;
  logic        c8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t sb8[$];
  exp_t last = '0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder_serial_nbit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  adder_serial_nbit #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(c8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input int w);
    logic [16:0] t;
    exp_t        e;
    t = {1'b0, x} + {1'b0, y} + 17'(ci);
    if (w == 8) begin
      e.s  = {8'h00, t[7:0]};
      e.co = t[8];
      e.ov = (x[7] == y[7]) && (t[7] != x[7]);
    end else begin
      e.s  = t[15:0];
      e.co = t[16];
      e.ov = (x[15] == y[15]) && (t[15] != x[15]);
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic ci);
    a = x; b = y; carry_in = ci; start = 1'b1;
    sb.push_back(model(x, y, ci, 16));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int lat0);
    int   lat;
    bit   got;
    exp_t e;
    lat = lat0;
    got = 0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) got = 1;
      else begin
        checks++;
        if (busy !== 1'b1 || {sum, carry_out, overflow} !== last) begin
          errors++;
          $display("FAIL %s calc_phase: busy=%b out=%h required busy=1 out=%h",
                   name, busy, {sum, carry_out, overflow}, last);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 30 cycles", name);
    end else begin
      if (lat != N + 1) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, lat, N + 1);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: done with empty queue", name);
      end else begin
        e = sb.pop_front();
        if ({sum, carry_out, overflow, busy} !== {e, 1'b0}) begin
          errors++;
          $display("FAIL %s result: sum=%h co=%b ov=%b busy=%b required sum=%h co=%b ov=%b busy=0",
                   name, sum, carry_out, overflow, busy, e.s, e.co, e.ov);
        end
        last = e;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b required done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, sum, carry_out, overflow} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {busy, done, sum, carry_out, overflow});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    issue(16'hFFFF, 16'h0001, 1'b0); wait_result("ffff_plus_1", 0);
    issue(16'h7FFF, 16'h0001, 1'b0); wait_result("7fff_plus_1", 0);
    issue(16'h8000, 16'h8000, 1'b0); wait_result("8000_plus_8000", 0);
    issue(16'hFFFF, 16'h0000, 1'b1); wait_result("carry_in_ripple", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      wait_result("random", 0);
    end
  endtask

  task automatic test_hold();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00 || {sum, carry_out, overflow} !== last) begin
        errors++;
        $display("FAIL hold: busy=%b done=%b out=%h required 0 0 %h",
                 busy, done, {sum, carry_out, overflow}, last);
      end
    end
  endtask

  task automatic test_operand_change();
    issue(16'h0003, 16'h0004, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h1111;
    wait_result("operand_change", 1);
  endtask

  task automatic test_back_to_back();
    int   pulses;
    exp_t e;
    pulses = 0;
    a = 16'h1234; b = 16'h4321; carry_in = 1'b1; start = 1'b1;
    sb.push_back(model(16'h1234, 16'h4321, 1'b1, 16));
    sb.push_back(model(16'h1234, 16'h4321, 1'b1, 16));
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 9) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        checks++;
        if (cyc != 4 && cyc != 9) begin
          errors++;
          $display("FAIL b2b_timing: done after edge %0d required 4 or 9", cyc);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_scoreboard: done with empty queue");
        end else begin
          e = sb.pop_front();
          if ({sum, carry_out, overflow} !== e) begin
            errors++;
            $display("FAIL b2b_result: out=%h required %h", {sum, carry_out, overflow}, e);
          end
          last = e;
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses required 2", pulses);
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    stray = 0;
    a = 16'h00F0; b = 16'h0F00; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, carry_out, overflow} !== 19'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %h required 0", {busy, done, sum, carry_out, overflow});
    end
    last = '0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles required 0", stray);
    end
    issue(16'h0102, 16'h0304, 1'b1);
    wait_result("after_abort", 0);
  endtask

  task automatic test_reset_priority();
    int stray;
    stray = 0;
    a = 16'h0005; b = 16'h0006; carry_in = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    last = '0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || {sum, carry_out, overflow} !== last) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_priority: %0d bad cycles required 0", stray);
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci, input string name);
    exp_t e;
    int   lat;
    bit   got;
    a8 = x; b8 = y; c8 = ci; start8 = 1'b1;
    sb8.push_back(model({8'h00, x}, {8'h00, y}, ci, 8));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (done8 === 1'b1) got = 1;
      else begin
        checks++;
        if (busy8 !== 1'b1) begin
          errors++;
          $display("FAIL %s busy8: got %b required 1", name, busy8);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout8: no done within 10 cycles", name);
    end else if (lat != 2) begin
      errors++;
      $display("FAIL %s latency8: got %0d required 2", name, lat);
    end
    if (got) begin
      e = sb8.pop_front();
      checks++;
      if ({sum8, co8, ov8} !== {e.s[7:0], e.co, e.ov}) begin
        errors++;
        $display("FAIL %s result8: sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                 name, sum8, co8, ov8, e.s[7:0], e.co, e.ov);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_width8();
    run8(8'h80, 8'h80, 1'b0, "w8_80_80");
    run8(8'h7F, 8'h01, 1'b0, "w8_7f_01");
    run8(8'hFF, 8'h00, 1'b1, "w8_ff_cin");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_random();
    test_operand_change();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    test_reset_priority();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
